// File: rtl/cpu_types_pkg.sv
// Shared types for the multi-channel request unit.
//   ru_chan_state_t : per-channel request FSM state
//   ru_top_state_t  : run/drain/halt control state
//   RU_MAX_NCH      : largest supported channel count
package cpu_types_pkg;

  localparam int unsigned RU_MAX_NCH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } ru_chan_state_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ru_top_state_t;

endpackage

// File: rtl/request_unit_mc_if.sv
// Pipeline <-> memory request bundle for request_unit_mc.
//   ru modport : the request unit (consumes hits/requests, drives enables)
//   tb modport : the environment driving the request unit
//   NCH        : number of data channels
interface request_unit_mc_if #(
  parameter int unsigned NCH = 1
);

  logic           ihit;
  logic [NCH-1:0] dhit;
  logic [NCH-1:0] dREN;
  logic [NCH-1:0] dWEN;
  logic           cpu_halt;
  logic           imemREN;
  logic [NCH-1:0] dmemREN;
  logic [NCH-1:0] dmemWEN;
  logic           pc_en;
  logic           halt;
  logic           timeout;
  logic [NCH-1:0] req_err;

  modport ru (
    input  ihit, dhit, dREN, dWEN, cpu_halt,
    output imemREN, dmemREN, dmemWEN, pc_en, halt, timeout, req_err
  );

  modport tb (
    output ihit, dhit, dREN, dWEN, cpu_halt,
    input  imemREN, dmemREN, dmemWEN, pc_en, halt, timeout, req_err
  );

endinterface

// File: rtl/ru_channel.sv
// One data-channel request holder: captures a read/write on ihit,
// holds it until dhit, flags conflicting read+write requests.
//   CLK, nRST        : clock, async active-low reset
//   capture          : take a new request this edge (only honoured in IDLE)
//   cancel           : force back to IDLE (immediate halt)
//   dREN, dWEN, dhit : channel request inputs and completion
//   dmemREN, dmemWEN : request enables (decoded from the state register)
//   busy             : request outstanding
//   req_err          : sticky read+write conflict flag
module ru_channel
  import cpu_types_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  input  logic capture,
  input  logic cancel,
  input  logic dREN,
  input  logic dWEN,
  input  logic dhit,
  output logic dmemREN,
  output logic dmemWEN,
  output logic busy,
  output logic req_err
);

  ru_chan_state_t state_q;

  // Request FSM; writes win over reads when both are asserted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      req_err <= 1'b0;
    end else if (cancel) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            if (dWEN) begin
              state_q <= WR;
            end else if (dREN) begin
              state_q <= RD;
            end
            if (dREN && dWEN) begin
              req_err <= 1'b1;
            end
          end
        end
        RD, WR: begin
          if (dhit) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmemREN = (state_q == RD);
  assign dmemWEN = (state_q == WR);
  assign busy    = (state_q != IDLE);

endmodule

// File: rtl/request_unit_mc.sv
// Multi-channel memory request unit: per-channel data request holding,
// halt sequencing (drain or cancel), pipeline advance and request watchdog.
//   CLK, nRST : clock, async active-low reset
//   bus (ru)  : ihit, dhit, dREN, dWEN, cpu_halt in;
//               imemREN, dmemREN, dmemWEN, pc_en (combinational), halt,
//               timeout, req_err out
module request_unit_mc
  import cpu_types_pkg::*;
#(
  parameter int unsigned NCH           = 1,
  parameter int unsigned HALT_DRAIN    = 1,
  parameter int unsigned TIMEOUT_LIMIT = 255
) (
  input  logic          CLK,
  input  logic          nRST,
  request_unit_mc_if.ru bus
);

  localparam int unsigned   CW      = $clog2(TIMEOUT_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_LIMIT);
  localparam logic [CW-1:0] CNT_ARM = CW'(TIMEOUT_LIMIT - 1);

  ru_top_state_t  top_q;
  logic [CW-1:0]  wd_cnt;
  logic           timeout_q;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] ren;
  logic [NCH-1:0] wen;
  logic [NCH-1:0] err;
  logic           pending;
  logic           pending_nxt;
  logic           halt_req;
  logic           capture;
  logic           cancel;

  assign pending     = |busy;
  // Drain finishes on the edge where every busy channel sees its dhit.
  assign pending_nxt = |(busy & ~bus.dhit);
  assign halt_req    = (top_q == RUN) && bus.ihit && bus.cpu_halt;
  // The halting instruction itself never launches a data request.
  assign capture     = (top_q == RUN) && bus.ihit && !bus.cpu_halt;
  assign cancel      = halt_req && (HALT_DRAIN == 0);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ru_channel u_ch (
      .CLK     (CLK),
      .nRST    (nRST),
      .capture (capture),
      .cancel  (cancel),
      .dREN    (bus.dREN[i]),
      .dWEN    (bus.dWEN[i]),
      .dhit    (bus.dhit[i]),
      .dmemREN (ren[i]),
      .dmemWEN (wen[i]),
      .busy    (busy[i]),
      .req_err (err[i])
    );
  end

  // Run / drain / halted sequencing; HALTED is left only through reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      top_q <= RUN;
    end else begin
      case (top_q)
        RUN: begin
          if (halt_req) begin
            top_q <= (!pending || (HALT_DRAIN == 0)) ? HALTED : DRAIN;
          end
        end
        DRAIN: begin
          if (!pending_nxt) begin
            top_q <= HALTED;
          end
        end
        default: top_q <= HALTED;
      endcase
    end
  end

  // Saturating stuck-request counter with a sticky flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (pending) begin
      if (wd_cnt != CNT_MAX) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
      if (wd_cnt >= CNT_ARM) begin
        timeout_q <= 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
  end

  assign bus.imemREN = (top_q == RUN);
  assign bus.halt    = (top_q == HALTED);
  assign bus.timeout = timeout_q;
  assign bus.dmemREN = ren;
  assign bus.dmemWEN = wen;
  assign bus.req_err = err;
  assign bus.pc_en   = bus.ihit && !pending && (top_q != HALTED);

endmodule
